fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Sequencing controller for the 8-entry FIFO.
- Accepts `wr_en`/`rd_en` requests, arbitrates them against the full/empty condition, and drives write/read strobes and addresses to the FIFO storage array.
- Maintains `data_count` and publishes a 3-bit operation state consumed by the FIFO status/handshake decoder, which derives full/empty and ack/err.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two.
- AW, 3, address width; log2(DEPTH).
- CW, 4, count width; AW+1, so that DEPTH itself is representable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request for this cycle.
- rd_en  input  1  read request for this cycle.
- state  output  3  registered result of the last cycle's operation: INIT=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100.
- data_count  output  CW  registered number of valid entries, range 0..DEPTH.
- we  output  1  combinational write strobe to storage; storage captures din at the next clk edge.
- re  output  1  combinational read strobe to storage.
- wr_addr  output  AW  tail pointer; location written when `we`=1.
- rd_addr  output  AW  head pointer; location read when `re`=1.

Behaviour:
- Reset is synchronous, active-high; one clock; no other clock domain.
- Reset values: state=INIT, data_count=0, head=0, tail=0. During reset: we=0, re=0, wr_addr=0, rd_addr=0.
- Internal conditions: empty_i = (data_count==0); full_i = (data_count==DEPTH).
- Request decode each cycle, first match wins:
  - both idle (wr_en=0, rd_en=0): NOP; next state=INIT.
  - rd_en=1 and !empty_i: READ. re=1; head<=head+1; data_count<=data_count-1; next state=READ.
  - rd_en=1, wr_en=0, empty_i: RD_ERROR. No strobe; pointers and count unchanged.
  - wr_en=1 and !full_i: WRITE. we=1; tail<=tail+1; data_count<=data_count+1; next state=WRITE.
  - wr_en=1 and full_i: WR_ERROR. No strobe; pointers and count unchanged.
- Simultaneous wr_en=1 and rd_en=1:
  - Read has priority when not empty; write is dropped silently, no error flagged.
  - When empty, the write is performed; the read is dropped silently.
- we and re are never both 1 in the same cycle. At most one pointer moves per cycle.
- Latency: request in cycle N -> strobe in cycle N -> state/count/pointer updates visible in cycle N+1. The handshake decoder therefore asserts ack/err one cycle after the request.
- state holds a value for exactly one cycle per request; it returns to INIT on any idle cycle.
- Pointer arithmetic is modulo DEPTH; 7+1 wraps to 0 with no flag.
- data_count never exceeds DEPTH and never underflows below 0. The error paths guarantee this.
- Reset asserted mid-operation:
  - That cycle's request is discarded; strobes are forced to 0 in that cycle.
  - All registers return to reset values at the edge.
  - Storage contents are not cleared but are treated as invalid.
- Values 101..111 never appear on state.

Optional Feature:
- Macro: FIFO_CTRL_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [7:0] and input err_clr [1].
  - err_cnt increments by 1 on every cycle whose next state is WR_ERROR or RD_ERROR, saturating at 8'hFF.
  - err_clr=1 zeroes err_cnt at the next edge and takes priority over a same-cycle increment.
  - reset clears err_cnt.
- When undefined: neither port exists and all other behaviour is identical.

Test Plan:
- Reset, then 8 write cycles -> we=1 each cycle; wr_addr 0..7; data_count ends at 8; state=WRITE after each; tail wraps to 0.
- From full (count=8), wr_en=1 for 1 cycle -> we=0; next state=WR_ERROR; count stays 8; tail unchanged.
- From full, 8 read cycles then 1 more read -> rd_addr 0..7; count reaches 0; 9th read gives RD_ERROR with re=0.
- count=3, wr_en=rd_en=1 for 1 cycle -> re=1, we=0; count=2; state=READ. Then count=0, both asserted -> we=1; count=1; state=WRITE.
- Wrap test: 5 writes, 5 reads, 6 writes -> wr_addr sequence 5,6,7,0,1,2; count=6; no error states.
- Reset asserted mid-burst (count=4) alongside wr_en=1 -> we=0 that cycle; next cycle count=0, head=tail=0, state=INIT. With FIFO_CTRL_ERRCNT_EN, 3 RD_ERROR cycles -> err_cnt=3; then err_clr -> 0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Request/strobe bundle between a FIFO requester and fifo_ctrl.
// master drives requests, slave (fifo_ctrl) drives state, count, strobes and addresses.
interface fifo_ctrl_if #(
    parameter int AW = 3,
    parameter int CW = 4
);
    logic          wr_en;
    logic          rd_en;
    logic [2:0]    state;
    logic [CW-1:0] data_count;
    logic          we;
    logic          re;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    modport master (
        output wr_en, rd_en,
        input  state, data_count, we, re, wr_addr, rd_addr
    );

    modport slave (
        input  wr_en, rd_en,
        output state, data_count, we, re, wr_addr, rd_addr
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Sequencing controller for an 8-entry FIFO: arbitrates wr/rd against full/empty.
// Optional saturating error counter enabled by defining FIFO_CTRL_ERRCNT_EN.
//
// state       | meaning
// ------------+----------------------------------------------
// INIT   000  | reset or idle cycle (no request)
// WRITE  001  | last cycle wrote one entry
// READ   010  | last cycle read one entry
// WR_ERR 011  | last cycle requested a write while full
// RD_ERR 100  | last cycle requested a read while empty
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
`ifdef FIFO_CTRL_ERRCNT_EN
    input  logic         i_err_clr,
    output logic [7:0]   o_err_cnt,
`endif
    fifo_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_RD_ERROR = 3'b100
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic          w_empty;
    logic          w_full;
    logic          w_we;
    logic          w_re;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_next;
            if (w_re) begin
                r_head  <= r_head + 1'b1;
                r_count <= r_count - 1'b1;
            end else if (w_we) begin
                r_tail  <= r_tail + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Read wins a simultaneous request unless empty; the losing side is dropped silently.
    always_comb begin
        w_next = ST_INIT;
        if (!bus.wr_en && !bus.rd_en) begin
            w_next = ST_INIT;
        end else if (bus.rd_en && !w_empty) begin
            w_next = ST_READ;
        end else if (bus.rd_en && !bus.wr_en) begin
            w_next = ST_RD_ERROR;
        end else if (!w_full) begin
            w_next = ST_WRITE;
        end else begin
            w_next = ST_WR_ERROR;
        end
    end

    always_comb begin
        w_we = 1'b0;
        w_re = 1'b0;
        if (!i_reset) begin
            w_we = (w_next == ST_WRITE);
            w_re = (w_next == ST_READ);
        end
    end

    assign bus.we         = w_we;
    assign bus.re         = w_re;
    assign bus.state      = r_state;
    assign bus.data_count = r_count;
    assign bus.wr_addr    = i_reset ? '0 : r_tail;
    assign bus.rd_addr    = i_reset ? '0 : r_head;

`ifdef FIFO_CTRL_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err;

    assign w_err = (w_next == ST_WR_ERROR) || (w_next == ST_RD_ERROR);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed bench for fifo_ctrl against an occupancy-based reference model.
// Exercises the error counter too when FIFO_CTRL_ERRCNT_EN is defined.
module tb_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
`ifdef FIFO_CTRL_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    fifo_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
`ifdef FIFO_CTRL_ERRCNT_EN
        .i_err_clr (err_clr),
        .o_err_cnt (err_cnt),
`endif
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference: occupancy and head index; the tail is derived as head+count.
    int m_cnt   = 0;
    int m_head  = 0;
    int m_state = 0;
    int m_err   = 0;
    int n_errs_seen = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic rs, input logic clr);
        int nxt;
        int e_we;
        int e_re;
        @(negedge clk);
        bus.wr_en = w;
        bus.rd_en = r;
        rst       = rs;
        err_clr   = clr;
        #1;
        if (!w && !r)                 nxt = 0;
        else if (r && m_cnt > 0)      nxt = 2;
        else if (r && !w)             nxt = 4;
        else if (m_cnt < DEPTH)       nxt = 1;
        else                          nxt = 3;
        e_we = (!rs && nxt == 1) ? 1 : 0;
        e_re = (!rs && nxt == 2) ? 1 : 0;
        check("we", int'(bus.we), e_we);
        check("re", int'(bus.re), e_re);
        check("wr_addr", int'(bus.wr_addr), rs ? 0 : (m_head + m_cnt) % DEPTH);
        check("rd_addr", int'(bus.rd_addr), rs ? 0 : m_head);
        @(posedge clk);
        if (rs) begin
            m_cnt = 0; m_head = 0; m_state = 0; m_err = 0;
        end else begin
            m_state = nxt;
            if (nxt == 2) begin
                m_head = (m_head + 1) % DEPTH;
                m_cnt--;
            end else if (nxt == 1) begin
                m_cnt++;
            end
            if (nxt == 3 || nxt == 4) n_errs_seen++;
            if (clr) m_err = 0;
            else if ((nxt == 3 || nxt == 4) && m_err < 255) m_err++;
        end
        #1;
        check("state", int'(bus.state), m_state);
        check("data_count", int'(bus.data_count), m_cnt);
`ifdef FIFO_CTRL_ERRCNT_EN
        check("err_cnt", int'(err_cnt), m_err);
`endif
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        check("full_count", int'(bus.data_count), 8);
        cyc(1, 0, 0, 0);
        check("wr_error", int'(bus.state), 3);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
        check("rd_error", int'(bus.state), 4);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("both_read", int'(bus.state), 2);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("both_empty_write", int'(bus.state), 1);

        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
        check("wrap_count", int'(bus.data_count), 6);

        cyc(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("post_reset_state", int'(bus.state), 0);

        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
`ifdef FIFO_CTRL_ERRCNT_EN
        check("err_cnt_3", int'(err_cnt), 3);
`endif
        cyc(0, 0, 0, 1);
`ifdef FIFO_CTRL_ERRCNT_EN
        check("err_cnt_clr", int'(err_cnt), 0);
`endif

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
